pwm_output_controller: RTL and testbench

- Sequences the 16 output pins from the SPI-written config registers: static enables, per-channel PWM select and a shared 8-bit duty cycle.
- Owns the PWM timebase, which is a prescaler plus a 256-step counter.
- Shadows all config at period boundaries so SPI writes never cause glitches mid-period.
- Sits between the SPI register file and the top-level output pins.

---
 rtl/pwm_pkg.sv | 42 ++++
 rtl/pwm_timebase.sv | 52 +++++
 rtl/pwm_output_controller.sv | 141 ++++++++++++++
 tb/tb_pwm_output_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants, the controller state type and small helper functions for
// the PWM output controller.
//   NUM_CH       : number of output channels
//   STEP_W       : width of the PWM step counter / duty value
//   DUTY_FULL    : duty code that means "always high"
//   STAGGER_STEP : per-channel phase offset (in steps) when staggering is built
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int             NUM_CH       = 16;
  localparam int             STEP_W       = 8;
  localparam logic [7:0]     DUTY_FULL    = 8'hFF;
  localparam logic [7:0]     STAGGER_STEP = 8'd16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Full-scale duty is forced high so 0xFF means 100 %, not 255/256.
  function automatic logic pwm_compare(input logic [STEP_W-1:0] phase,
                                       input logic [STEP_W-1:0] duty);
    logic result;
    if (duty == DUTY_FULL) begin
      result = 1'b1;
    end else begin
      result = (phase < duty);
    end
    return result;
  endfunction

  // Channel phase when staggering: step + 16*ch, wrapping modulo 256.
  function automatic logic [STEP_W-1:0] stagger_phase(input logic [STEP_W-1:0] step,
                                                      input int                ch);
    logic [STEP_W-1:0] offset;
    offset = 8'(int'(STAGGER_STEP) * ch);
    return step + offset;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// PWM timebase: a prescaler counting 0..PRESCALE-1 and an 8-bit step counter
// that advances once per prescaler wrap. Both are held at zero while run is low.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset
//   run      in  count enable (controller in RUN state)
//   step     out current PWM step 0..255
//   boundary out high on the last clock of a period (step 255, prescaler last)
// -----------------------------------------------------------------------------
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE   = 13,
  parameter int PRESCALE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [STEP_W-1:0] step,
  output logic              boundary
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] r_presc;
  logic [STEP_W-1:0]     r_step;
  logic                  w_presc_last;

  assign w_presc_last = (r_presc == PRESC_LAST);
  assign boundary     = run && w_presc_last && (r_step == 8'hFF);
  assign step         = r_step;

  // Prescaler and step counter; step wraps 255 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_step  <= 8'h00;
    end else if (!run) begin
      r_presc <= '0;
      r_step  <= 8'h00;
    end else if (w_presc_last) begin
      r_presc <= '0;
      r_step  <= r_step + 8'd1;
    end else begin
      r_presc <= r_presc + PRESCALE_W'(1);
      r_step  <= r_step;
    end
  end

endmodule

// File: rtl/pwm_output_controller.sv
// -----------------------------------------------------------------------------
// pwm_output_controller
// Drives 16 output pins from the SPI config registers: static enables, a
// per-channel PWM select and one shared 8-bit duty value. Config is shadowed
// every cycle while IDLE and only at period boundaries while RUN, so register
// writes never glitch an output mid-period.
// Build option: PWM_PHASE_STAGGER_EN -- when defined, channel i compares the
// duty against (step + 16*i) mod 256 to spread edges; default is phase-aligned.
// Ports:
//   clk              in   system clock
//   rst_n            in   synchronous active-low reset
//   en_reg_out_7_0   in   static output enables, ch 7..0
//   en_reg_out_15_8  in   static output enables, ch 15..8
//   en_reg_pwm_7_0   in   PWM select, ch 7..0
//   en_reg_pwm_15_8  in   PWM select, ch 15..8
//   pwm_duty_cycle   in   shared duty value
//   out              out  channel outputs, registered
//   running          out  high in RUN state
//   period_tick      out  one-cycle pulse after the last cycle of a period
// -----------------------------------------------------------------------------
module pwm_output_controller
  import pwm_pkg::*;
#(
  parameter int PRESCALE   = 13,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        running,
  output logic        period_tick
);

  logic [NUM_CH-1:0] w_en_out_in;
  logic [NUM_CH-1:0] w_en_pwm_in;
  logic [STEP_W-1:0] w_step;
  logic              w_boundary;
  logic              w_run;
  logic [NUM_CH-1:0] w_pwm_raw;
  logic [NUM_CH-1:0] w_out_next;

  state_e            r_state;
  logic [NUM_CH-1:0] r_en_out_sh;
  logic [NUM_CH-1:0] r_en_pwm_sh;
  logic [STEP_W-1:0] r_duty_sh;
  logic [NUM_CH-1:0] r_out;
  logic              r_running;
  logic              r_period_tick;

  assign w_en_out_in = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm_in = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_run       = (r_state == RUN);

  pwm_timebase #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (w_run),
    .step     (w_step),
    .boundary (w_boundary)
  );

  // Per-channel compare against the (optionally staggered) step.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [STEP_W-1:0] w_phase;
`ifdef PWM_PHASE_STAGGER_EN
    assign w_phase = stagger_phase(w_step, g);
`else
    assign w_phase = w_step;
`endif
    assign w_pwm_raw[g] = pwm_compare(w_phase, r_duty_sh);
  end

  // Enabled channels follow PWM if selected, else are static high.
  assign w_out_next = r_en_out_sh & (~r_en_pwm_sh | w_pwm_raw);

  // Controller FSM, config shadows and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_en_out_sh   <= 16'h0000;
      r_en_pwm_sh   <= 16'h0000;
      r_duty_sh     <= 8'h00;
      r_out         <= 16'h0000;
      r_running     <= 1'b0;
      r_period_tick <= 1'b0;
    end else begin
      r_out         <= w_out_next;
      r_period_tick <= w_boundary;
      case (r_state)
        IDLE: begin
          r_en_out_sh <= w_en_out_in;
          r_en_pwm_sh <= w_en_pwm_in;
          r_duty_sh   <= pwm_duty_cycle;
          // Start decision uses the already-shadowed enables.
          if (r_en_out_sh != 16'h0000) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        end
        RUN: begin
          if (w_boundary) begin
            r_en_out_sh <= w_en_out_in;
            r_en_pwm_sh <= w_en_pwm_in;
            r_duty_sh   <= pwm_duty_cycle;
            // Stop decision uses the value being loaded now.
            if (w_en_out_in == 16'h0000) begin
              r_state   <= IDLE;
              r_running <= 1'b0;
            end else begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end else begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign running     = r_running;
  assign period_tick = r_period_tick;

endmodule

// File: tb/tb_pwm_output_controller.sv
module tb_pwm_output_controller;

  localparam int P      = 13;
  localparam int PERIOD = 256 * P;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int OFS = 16;
`else
  localparam int OFS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        running;
  logic        period_tick;

  int n_checks = 0;
  int n_errors = 0;

  pwm_output_controller #(.PRESCALE(P), .PRESCALE_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .running         (running),
    .period_tick     (period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    pwm_duty_cycle = d;
  endtask

  // ---------------- behavioural reference model ----------------
  // Time within the period is tracked as a clock count; step = t / P.
  function automatic logic [15:0] exp_out(input logic [15:0] eo, input logic [15:0] ep,
                                          input logic [7:0] d, input int t);
    logic [15:0] r;
    int ph;
    logic hi;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      ph = ((t / P) + OFS * i) % 256;
      hi = (d == 8'hFF) || (ph < int'(d));
      r[i] = eo[i] & (~ep[i] | hi);
    end
    return r;
  endfunction

  logic [15:0] m_eo, m_ep, m_out;
  logic [7:0]  m_d;
  logic        m_run, m_tick;
  int          m_t;
  bit          mdl_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_eo <= 16'h0000; m_ep <= 16'h0000; m_d <= 8'h00;
      m_out <= 16'h0000; m_run <= 1'b0; m_tick <= 1'b0; m_t <= 0;
    end else begin
      m_out  <= exp_out(m_eo, m_ep, m_d, m_t);
      m_tick <= m_run && (m_t == PERIOD - 1);
      if (!m_run) begin
        m_eo <= {en_reg_out_15_8, en_reg_out_7_0};
        m_ep <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
        m_d  <= pwm_duty_cycle;
        m_t  <= 0;
        m_run <= (m_eo != 16'h0000);
      end else if (m_t == PERIOD - 1) begin
        m_eo <= {en_reg_out_15_8, en_reg_out_7_0};
        m_ep <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
        m_d  <= pwm_duty_cycle;
        m_t  <= 0;
        m_run <= ({en_reg_out_15_8, en_reg_out_7_0} != 16'h0000);
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_en) chk("model", {14'd0, out, running, period_tick}, {14'd0, m_out, m_run, m_tick});
  end

  // ---------------- helper sequences ----------------
  task automatic reset_then_start(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    set_in(16'hFFFF, 16'hFFFF, 8'h80);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", {15'd0, out, running, period_tick}, 32'd0);
    set_in(eo, ep, d);
    rst_n = 1'b1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!period_tick && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", {31'd0, period_tick}, 32'd1);
  endtask

  // Starts on a tick sample; counts out[0] high cycles up to and including the next tick.
  task automatic measure(input int chg_at, input logic [15:0] eo, input logic [7:0] d,
                         output int hi, output int len);
    hi = 0;
    len = 0;
    do begin
      if (len == chg_at) begin
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        pwm_duty_cycle = d;
      end
      @(negedge clk);
      len++;
      if (out[0]) hi++;
    end while (!period_tick && len < 2 * PERIOD);
  endtask

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  d;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int hi, len, bad;
    logic [15:0] r_eo;
    rst_n = 1'b0;
    set_in(16'h0000, 16'h0000, 8'h00);
    repeat (2) @(negedge clk);
    mdl_en = 1'b1;

    // Output at T+2 from IDLE, step 0 (stagger-insensitive choices).
    vecs[0] = '{16'h0001, 16'h0000, 8'h00, 16'h0001};
    vecs[1] = '{16'h00FF, 16'h00FF, 8'h80, 16'h00FF};
    vecs[2] = '{16'h00FF, 16'h00FF, 8'h00, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'hFF00, 8'h00, 16'h00FF};
    vecs[4] = '{16'h0F0F, 16'hFFFF, 8'hFF, 16'h0F0F};
    vecs[5] = '{16'h0000, 16'hFFFF, 8'h80, 16'h0000};
    vecs[6] = '{16'hA5A5, 16'h0001, 8'h01, 16'hA5A5};
    for (int i = 0; i < 7; i++) begin
      reset_then_start(vecs[i].eo, vecs[i].ep, vecs[i].d);
      @(negedge clk);
      chk("tbl_t1_out", {16'd0, out}, 32'd0);
      @(negedge clk);
      chk("tbl_t2_out", {16'd0, out}, {16'd0, vecs[i].exp});
      chk("tbl_t2_run", {31'd0, running}, {31'd0, vecs[i].eo != 16'h0000});
    end

    // Static output steady for three periods.
    reset_then_start(16'h0001, 16'h0000, 8'h00);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      if (out !== 16'h0001 || running !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("static_steady_bad", bad, 0);

    // 50 % duty, then disable at step 50.
    reset_then_start(16'h00FF, 16'h00FF, 8'h80);
    wait_tick();
    measure(-1, 16'h00FF, 8'h80, hi, len);
    chk("d50_high", hi, 1664);
    chk("d50_len", len, PERIOD);
    chk("d50_upper", {24'd0, out[15:8]}, 32'd0);
    measure(50 * P, 16'h0000, 8'h80, hi, len);
    chk("dis_high", hi, 1664);
    chk("dis_run_at_tick", {31'd0, running}, 32'd0);
    @(negedge clk);
    chk("dis_out_after", {16'd0, out}, 32'd0);

    // Mid-period duty change 0x40 -> 0xC0 at step 100.
    reset_then_start(16'h0001, 16'h0001, 8'h40);
    wait_tick();
    measure(100 * P, 16'h0001, 8'hC0, hi, len);
    chk("chg_cur_high", hi, 832);
    measure(-1, 16'h0001, 8'hC0, hi, len);
    chk("chg_next_high", hi, 2496);

    // Duty extremes.
    reset_then_start(16'hFFFF, 16'hFFFF, 8'h00);
    wait_tick();
    measure(100 * P, 16'hFFFF, 8'hFF, hi, len);
    chk("duty0_high", hi, 0);
    measure(-1, 16'hFFFF, 8'hFF, hi, len);
    chk("dutyFF_high", hi, PERIOD);
    measure(-1, 16'hFFFF, 8'hFF, hi, len);
    chk("dutyFF_high2", hi, PERIOD);

    // Randomized stimulus against the reference model, with a mid-run reset.
    for (int s = 0; s < 12; s++) begin
      r_eo = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      case ($urandom_range(0, 2))
        0: set_in(r_eo, 16'($urandom), 8'h00);
        1: set_in(r_eo, 16'($urandom), 8'hFF);
        default: set_in(r_eo, 16'($urandom), 8'($urandom));
      endcase
      if (s == 6) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 3000)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
